// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command-frame controller: FSM states,
// default sync marker, frame geometry and the frame checksum.
package uart_cmd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DHI   = 3'd2,
      ST_DLO   = 3'd3,
      ST_CHK   = 3'd4,
      ST_ISSUE = 3'd5
   } state_e;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int unsigned FRAME_LEN         = 5;

   function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                            input logic [7:0] data_hi,
                                            input logic [7:0] data_lo);
      return addr ^ data_hi ^ data_lo;
   endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Converts the receiver's byte-complete level into a one-cycle strobe and
// presents the byte that belongs to it.
module uart_byte_strobe (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_status,
   input  logic [7:0] rx_data,
   output logic       byte_stb,
   output logic [7:0] rx_byte
);

   logic       rx_status_q, rx_status_d;
   logic [7:0] data_q, data_d;

   // Delay register resets high so a level already up at reset release is not a byte.
   always_comb begin
      byte_stb    = rx_status & ~rx_status_q;
      rx_status_d = rx_status;
      data_d      = byte_stb ? rx_data : data_q;
      rx_byte     = byte_stb ? rx_data : data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_status_q <= 1'b1;
         data_q      <= '0;
      end else begin
         rx_status_q <= rx_status_d;
         data_q      <= data_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 5-byte SYNC/ADDR/DHI/DLO/CHK frames from UART bytes and issues one
// valid/ready write command per good frame, with timeout, overrun and statistics.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter logic [15:0] TIMEOUT   = 16'd2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_status,
   input  logic        cmd_ready,
   output logic        cmd_valid,
   output logic [7:0]  cmd_addr,
   output logic [15:0] cmd_data,
   output logic        err_chk,
   output logic        err_timeout,
   output logic        err_overrun,
   output logic [7:0]  frames_ok,
   output logic [7:0]  frames_bad,
   output logic        busy
);

   logic       byte_stb;
   logic [7:0] rx_byte;

   uart_byte_strobe u_byte_strobe (
      .clk       (clk),
      .rst       (rst),
      .rx_status (rx_status),
      .rx_data   (rx_data),
      .byte_stb  (byte_stb),
      .rx_byte   (rx_byte)
   );

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
   logic        err_chk_q, err_chk_d, err_to_q, err_to_d, err_ov_q, err_ov_d;
   logic [7:0]  ok_q, ok_d, bad_q, bad_d;
   logic        inc_ok, inc_bad;

   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      addr_d   = addr_q;
      dhi_d    = dhi_q;
      dlo_d    = dlo_q;
      err_chk_d = 1'b0;
      err_to_d  = 1'b0;
      err_ov_d  = 1'b0;
      inc_ok   = 1'b0;
      inc_bad  = 1'b0;

      case (state_q)
         ST_HUNT: begin
            if (byte_stb && rx_byte == SYNC_BYTE) state_d = ST_ADDR;
         end
         ST_ADDR, ST_DHI, ST_DLO, ST_CHK: begin
            // A byte arriving on the timeout cycle takes priority over the timeout.
            if (byte_stb) begin
               case (state_q)
                  ST_ADDR: begin addr_d = rx_byte; state_d = ST_DHI; end
                  ST_DHI:  begin dhi_d  = rx_byte; state_d = ST_DLO; end
                  ST_DLO:  begin dlo_d  = rx_byte; state_d = ST_CHK; end
                  default: begin
                     if (rx_byte == frame_chk(addr_q, dhi_q, dlo_q)) begin
                        inc_ok  = 1'b1;
                        state_d = ST_ISSUE;
                     end else begin
                        err_chk_d = 1'b1;
                        inc_bad   = 1'b1;
                        state_d   = ST_HUNT;
                     end
                  end
               endcase
            end else if (cnt_q == TIMEOUT - 16'd1) begin
               err_to_d = 1'b1;
               inc_bad  = 1'b1;
               state_d  = ST_HUNT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_ISSUE: begin
            if (byte_stb) begin
               err_ov_d = 1'b1;
               inc_bad  = 1'b1;
            end
            if (cmd_ready) state_d = ST_HUNT;
         end
         default: state_d = ST_HUNT;
      endcase

      ok_d  = (inc_ok  && ok_q  != '1) ? ok_q  + 8'd1 : ok_q;
      bad_d = (inc_bad && bad_q != '1) ? bad_q + 8'd1 : bad_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_HUNT;
         cnt_q     <= '0;
         addr_q    <= '0;
         dhi_q     <= '0;
         dlo_q     <= '0;
         err_chk_q <= 1'b0;
         err_to_q  <= 1'b0;
         err_ov_q  <= 1'b0;
         ok_q      <= '0;
         bad_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         dhi_q     <= dhi_d;
         dlo_q     <= dlo_d;
         err_chk_q <= err_chk_d;
         err_to_q  <= err_to_d;
         err_ov_q  <= err_ov_d;
         ok_q      <= ok_d;
         bad_q     <= bad_d;
      end
   end

   assign cmd_valid   = (state_q == ST_ISSUE);
   assign busy        = (state_q != ST_HUNT);
   assign cmd_addr    = addr_q;
   assign cmd_data    = {dhi_q, dlo_q};
   assign err_chk     = err_chk_q;
   assign err_timeout = err_to_q;
   assign err_overrun = err_ov_q;
   assign frames_ok   = ok_q;
   assign frames_bad  = bad_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frame scenarios plus randomized traffic,
// checked every cycle against a byte/frame-level reference model.
module tb_uart_cmd_ctrl;
   import uart_cmd_ctrl_pkg::*;

   localparam int          TMO  = 2000;
   localparam logic [7:0]  SYNC = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_status = 1'b1;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        err_chk, err_timeout, err_overrun, busy;
   logic [7:0]  frames_ok, frames_bad;

   uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT(16'(TMO))) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_status(rx_status),
      .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .err_chk(err_chk), .err_timeout(err_timeout),
      .err_overrun(err_overrun), .frames_ok(frames_ok), .frames_bad(frames_bad),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frames as a byte queue, command as a pending record.
   logic       m_prev = 1'b1;
   logic       m_collect = 1'b0;
   logic [7:0] m_fb[$];
   int         m_idle = 0;
   logic       m_pend = 1'b0;
   logic [7:0] m_addr = '0;
   logic [15:0] m_data = '0;
   int         m_ok = 0, m_bad = 0;
   logic       m_echk = 0, m_eto = 0, m_eov = 0;
   int         cyc = 0, stb_cyc = 0;

   task automatic model_step();
      logic       stb;
      logic [7:0] b;
      cyc++;
      if (rst) begin
         m_prev = 1'b1; m_collect = 0; m_fb.delete(); m_idle = 0; m_pend = 0;
         m_ok = 0; m_bad = 0; m_echk = 0; m_eto = 0; m_eov = 0;
         return;
      end
      stb = rx_status && !m_prev;
      m_prev = rx_status;
      b = rx_data;
      m_echk = 0; m_eto = 0; m_eov = 0;
      if (stb) stb_cyc = cyc;
      if (m_pend) begin
         if (stb) begin m_eov = 1; if (m_bad < 255) m_bad++; end
         if (cmd_ready) m_pend = 0;
      end else if (!m_collect) begin
         if (stb && b == SYNC) begin m_collect = 1; m_fb.delete(); m_idle = 0; end
      end else if (stb) begin
         m_fb.push_back(b);
         m_idle = 0;
         if (m_fb.size() == FRAME_LEN - 1) begin
            m_collect = 0;
            if (m_fb[3] == (m_fb[0] ^ m_fb[1] ^ m_fb[2])) begin
               m_pend = 1; m_addr = m_fb[0]; m_data = {m_fb[1], m_fb[2]};
               if (m_ok < 255) m_ok++;
            end else begin
               m_echk = 1; if (m_bad < 255) m_bad++;
            end
         end
      end else begin
         m_idle++;
         if (m_idle >= TMO) begin m_eto = 1; m_collect = 0; if (m_bad < 255) m_bad++; end
      end
   endtask

   // Observed DUT events
   int          n_cmd = 0, n_chk = 0, n_to = 0, n_ov = 0, to_cyc = 0;
   logic [7:0]  last_addr = '0;
   logic [15:0] last_data = '0;

   initial forever begin
      @(posedge clk);
      if (!rst && cmd_valid && cmd_ready) begin
         n_cmd++; last_addr = cmd_addr; last_data = cmd_data;
      end
      model_step();
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("cmd_valid", 32'(cmd_valid), 32'(m_pend));
         chk("busy", 32'(busy), 32'(m_collect | m_pend));
         chk("err_chk", 32'(err_chk), 32'(m_echk));
         chk("err_timeout", 32'(err_timeout), 32'(m_eto));
         chk("err_overrun", 32'(err_overrun), 32'(m_eov));
         chk("frames_ok", 32'(frames_ok), 32'(m_ok));
         chk("frames_bad", 32'(frames_bad), 32'(m_bad));
         if (m_pend) begin
            chk("cmd_addr", 32'(cmd_addr), 32'(m_addr));
            chk("cmd_data", 32'(cmd_data), 32'(m_data));
         end
         if (err_chk) n_chk++;
         if (err_overrun) n_ov++;
         if (err_timeout) begin n_to++; to_cyc = cyc; end
      end
   end

   logic rand_ready = 1'b0;
   initial forever begin
      @(negedge clk);
      if (rand_ready) cmd_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
      @(negedge clk);
      rx_data = b; rx_status = 1'b1;
      repeat (hi) @(negedge clk);
      rx_status = 1'b0; rx_data = 8'($urandom);
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                             input logic [7:0] l, input logic [7:0] c);
      send_byte(SYNC, 2, 2); send_byte(a, 2, 2); send_byte(h, 2, 2);
      send_byte(l, 2, 2); send_byte(c, 2, 2);
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while ((busy || cmd_valid) && k < max) begin @(negedge clk); k++; end
      if (busy || cmd_valid) begin
         n_total++; n_bad++;
         $display("FAIL wait_idle: still busy after %0d cycles, want idle", max);
      end
   endtask

   task automatic wait_valid(input int max);
      int k = 0;
      while (!cmd_valid && k < max) begin @(negedge clk); k++; end
      if (!cmd_valid) begin
         n_total++; n_bad++;
         $display("FAIL wait_valid: cmd_valid=0 after %0d cycles, want 1", max);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(cmd_valid), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_addr"}, 32'(cmd_addr), 0);
      chk({tag, "_data"}, 32'(cmd_data), 0);
      chk({tag, "_errs"}, 32'({err_chk, err_timeout, err_overrun}), 0);
      chk({tag, "_ok"}, 32'(frames_ok), 0);
      chk({tag, "_bad"}, 32'(frames_bad), 0);
   endtask

   int base_cmd, base_chk, base_ov, base_to, kind, nb, n_tmo_rand;
   logic [7:0] a, h, l;

   initial begin
      // Reset with rx_status already high; a spurious strobe would see a SYNC byte.
      rx_data = SYNC;
      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(4);
      chk("no_spurious_busy", 32'(busy), 0);
      rx_status = 1'b0;
      tick(2);

      // Good frame, ready high
      cmd_ready = 1'b1;
      base_cmd = n_cmd;
      send_frame(8'h12, 8'h34, 8'h56, 8'h70);
      wait_idle(100);
      chk("good_ncmd", n_cmd - base_cmd, 1);
      chk("good_addr", 32'(last_addr), 32'h12);
      chk("good_data", 32'(last_data), 32'h3456);
      chk("good_ok", 32'(frames_ok), 1);
      chk("good_bad", 32'(frames_bad), 0);

      // Bad checksum
      base_cmd = n_cmd; base_chk = n_chk;
      send_frame(8'h12, 8'h34, 8'h56, 8'h71);
      tick(2);
      chk("badchk_pulses", n_chk - base_chk, 1);
      chk("badchk_bad", 32'(frames_bad), 1);
      chk("badchk_ncmd", n_cmd - base_cmd, 0);
      chk("badchk_busy", 32'(busy), 0);

      // Leading garbage
      base_cmd = n_cmd;
      send_byte(8'h00, 1, 2); send_byte(8'hFF, 1, 2);
      send_frame(8'h01, 8'h00, 8'h02, 8'h03);
      wait_idle(100);
      chk("garbage_ncmd", n_cmd - base_cmd, 1);
      chk("garbage_addr", 32'(last_addr), 32'h01);
      chk("garbage_data", 32'(last_data), 32'h0002);
      chk("garbage_bad", 32'(frames_bad), 1);

      // Backpressure with overrun byte
      cmd_ready = 1'b0;
      base_cmd = n_cmd; base_ov = n_ov;
      send_frame(8'h77, 8'hAB, 8'hCD, 8'h11);
      wait_valid(50);
      tick(250);
      send_byte(8'h5A, 2, 2);
      tick(250);
      chk("bp_valid", 32'(cmd_valid), 1);
      chk("bp_addr", 32'(cmd_addr), 32'h77);
      chk("bp_data", 32'(cmd_data), 32'hABCD);
      chk("bp_overrun", n_ov - base_ov, 1);
      chk("bp_bad", 32'(frames_bad), 2);
      cmd_ready = 1'b1;
      wait_idle(10);
      chk("bp_ncmd", n_cmd - base_cmd, 1);

      // Inter-byte timeout
      base_to = n_to;
      send_byte(SYNC, 2, 2); send_byte(8'h10, 2, 2);
      begin
         int k = 0;
         while (n_to == base_to && k < TMO + 50) begin @(negedge clk); k++; end
      end
      chk("tmo_pulses", n_to - base_to, 1);
      chk("tmo_distance", to_cyc - stb_cyc, TMO);
      chk("tmo_bad", 32'(frames_bad), 3);
      chk("tmo_busy", 32'(busy), 0);
      base_cmd = n_cmd;
      send_frame(8'h20, 8'h00, 8'h01, 8'h21);
      wait_idle(100);
      chk("tmo_after_ncmd", n_cmd - base_cmd, 1);
      chk("tmo_after_ok", 32'(frames_ok), 4);

      // Reset mid-frame with rx_status held high across release
      send_byte(SYNC, 2, 2);
      @(negedge clk); rx_data = SYNC; rx_status = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(1);
      check_zero("rst_frame");
      tick(1);
      rst = 1'b0;
      tick(3);
      chk("rst_frame_busy", 32'(busy), 0);
      rx_status = 1'b0;
      tick(1);
      base_cmd = n_cmd;
      send_frame(8'h12, 8'h34, 8'h56, 8'h70);
      wait_idle(100);
      chk("rst_frame_ncmd", n_cmd - base_cmd, 1);
      chk("rst_frame_ok", 32'(frames_ok), 1);

      // Reset while a command is pending
      cmd_ready = 1'b0;
      base_cmd = n_cmd;
      send_frame(8'h44, 8'h55, 8'h66, 8'h44 ^ 8'h55 ^ 8'h66);
      wait_valid(50);
      tick(5);
      rst = 1'b1;
      tick(1);
      check_zero("rst_issue");
      rst = 1'b0;
      tick(2);
      chk("rst_issue_ncmd", n_cmd - base_cmd, 0);
      cmd_ready = 1'b1;
      send_frame(8'h01, 8'h02, 8'h03, 8'h00);
      wait_idle(100);
      chk("rst_issue_after", n_cmd - base_cmd, 1);

      // Randomized traffic with random backpressure
      rand_ready = 1'b1;
      n_tmo_rand = 0;
      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 9);
         a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
         if (kind <= 4) begin
            send_byte(SYNC, $urandom_range(1, 3), $urandom_range(1, 10));
            send_byte(a, $urandom_range(1, 3), $urandom_range(1, 10));
            send_byte(h, $urandom_range(1, 3), $urandom_range(1, 10));
            send_byte(l, $urandom_range(1, 3), $urandom_range(1, 10));
            send_byte(a ^ h ^ l, $urandom_range(1, 3), $urandom_range(1, 10));
         end else if (kind <= 6) begin
            send_frame(a, h, l, a ^ h ^ l ^ 8'(1 << $urandom_range(0, 7)));
         end else if (kind == 8 && n_tmo_rand < 2) begin
            n_tmo_rand++;
            nb = $urandom_range(0, 3);
            send_byte(SYNC, 2, 2);
            for (int j = 0; j < nb; j++) send_byte(8'($urandom), 2, 2);
            tick(TMO + 10);
         end else begin
            send_byte(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 12));
         end
      end
      rand_ready = 1'b0;
      cmd_ready = 1'b1;
      tick(TMO + 10);
      wait_idle(100);

      // Counter saturation
      rst = 1'b1; tick(2); rst = 1'b0; tick(2);
      for (int i = 0; i < 260; i++) begin
         send_byte(SYNC, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h02, 1, 1);
         send_byte(8'h03, 1, 1); send_byte(8'hFF, 1, 1);
      end
      tick(3);
      chk("sat_bad", 32'(frames_bad), 32'hFF);
      for (int i = 0; i < 260; i++) begin
         send_byte(SYNC, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h02, 1, 1);
         send_byte(8'h03, 1, 1); send_byte(8'h00, 1, 1);
      end
      wait_idle(20);
      chk("sat_ok", 32'(frames_ok), 32'hFF);
      chk("sat_bad_hold", 32'(frames_bad), 32'hFF);

      tick(3);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
